// File: rtl/carfield_l2_scrubber.sv
// Background ECC scrubber for one L2 port: walks every word, writes back corrected data,
// counts correctable/uncorrectable errors and logs the first uncorrectable address.
module carfield_l2_scrubber #(
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 64,
  parameter logic [AddrWidth-1:0] BaseAddr  = 'h7800_0000,
  parameter int unsigned          NumWords  = 262144,
  parameter int unsigned          CntWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 scrub_en_i,
  input  logic [15:0]          interval_i,
  input  logic                 clear_i,
  input  logic                 func_req_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic                 mem_ce_i,
  input  logic                 mem_ue_i,
  output logic [CntWidth-1:0]  ce_count_o,
  output logic [CntWidth-1:0]  ue_count_o,
  output logic [AddrWidth-1:0] ue_addr_o,
  output logic                 irq_ue_o,
  output logic                 sweep_done_o
);

  // state | meaning
  // IDLE  | scrubbing disabled, index retained
  // WAIT  | idle gap counting down from interval_i
  // RD    | read request pending, yields to functional traffic
  // RSP   | waiting for the read response
  // WB    | writing back the corrected word
  // NXT   | advance index, pulse sweep_done on wrap
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] RSP  = 3'd3;
  localparam logic [2:0] WB   = 3'd4;
  localparam logic [2:0] NXT  = 3'd5;

  localparam int unsigned IdxWidth = $clog2(NumWords);
  localparam int unsigned Stride   = DataWidth / 8;

  logic [2:0]          state;
  logic [IdxWidth-1:0] idx;
  logic [15:0]         wait_cnt;
  logic                xfer;
  logic                last_word;
  logic                ce_hit;
  logic                ue_hit;

  // A read is only offered while enabled so a late disable never strands a response.
  assign mem_req_o    = ((state == RD && scrub_en_i) || state == WB) && !func_req_i;
  assign mem_we_o     = (state == WB);
  assign xfer         = mem_req_o && mem_gnt_i;
  assign mem_addr_o   = BaseAddr + AddrWidth'(idx) * AddrWidth'(Stride);
  assign last_word    = (idx == IdxWidth'(NumWords - 1));
  assign sweep_done_o = (state == NXT) && last_word;
  assign ce_hit       = (state == RSP) && mem_rvalid_i && mem_ce_i && !mem_ue_i;
  assign ue_hit       = (state == RSP) && mem_rvalid_i && mem_ue_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: if (scrub_en_i) begin
          state    <= WAIT;
          wait_cnt <= interval_i;
        end
        WAIT: begin
          if (!scrub_en_i)         state    <= IDLE;
          else if (wait_cnt == '0) state    <= RD;
          else                     wait_cnt <= wait_cnt - 16'd1;
        end
        RD: begin
          if (!scrub_en_i) state <= IDLE;
          else if (xfer)   state <= RSP;
        end
        RSP: if (mem_rvalid_i) begin
          if (mem_ue_i) begin
            state <= NXT;
          end else if (mem_ce_i) begin
            mem_wdata_o <= mem_rdata_i;
            state       <= WB;
          end else begin
            state <= NXT;
          end
        end
        WB: if (xfer) state <= NXT;
        NXT: begin
          idx <= last_word ? '0 : idx + IdxWidth'(1);
          if (scrub_en_i) begin
            state    <= WAIT;
            wait_cnt <= interval_i;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear takes precedence over any same-cycle increment or capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ce_count_o <= '0;
      ue_count_o <= '0;
      ue_addr_o  <= '0;
      irq_ue_o   <= 1'b0;
    end else if (clear_i) begin
      ce_count_o <= '0;
      ue_count_o <= '0;
      ue_addr_o  <= '0;
      irq_ue_o   <= 1'b0;
    end else begin
      if (ce_hit && ce_count_o != '1) ce_count_o <= ce_count_o + CntWidth'(1);
      if (ue_hit) begin
        if (ue_count_o != '1) ue_count_o <= ue_count_o + CntWidth'(1);
        if (!irq_ue_o) begin
          ue_addr_o <= mem_addr_o;
          irq_ue_o  <= 1'b1;
        end
      end
    end
  end

endmodule
